regfile: RTL and testbench

- Architectural integer register file: 32 x 32-bit, x0 hardwired to zero.
- Answers the decode stage's two read requests (rs1/rs2 enable + address → data) in the same cycle.
- Accepts one write per cycle from write-back.
- Provides same-cycle write-to-read bypass, a debug read port and a retired-write counter for bench and diagnostic use.

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/regfile_rd_port.sv | 30 +++
 rtl/regfile.sv | 84 ++++++++
 tb/tb_regfile.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and constants: word/address types, reset and
// enable polarities, and the write-back request bundle seen by read ports.
package regfile_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_NUM    = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_W-1:0]      reg_word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_word_t ZERO_WORD    = '0;
  localparam logic      RST_ENABLE   = 1'b1;
  localparam logic      READ_ENABLE  = 1'b1;
  localparam logic      WRITE_ENABLE = 1'b1;
  localparam reg_addr_t NOP_REG_ADDR = '0;

  typedef struct packed {
    logic      we;
    reg_addr_t addr;
    reg_word_t data;
  } wr_req_t;

  // True when the in-flight write targets this (non-x0) register.
  function automatic logic wr_hits(wr_req_t wr, reg_addr_t raddr);
    return (wr.we == WRITE_ENABLE) && (wr.addr == raddr) && (raddr != NOP_REG_ADDR);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// Combinational read port: reset/enable/x0 gating, then same-cycle write
// bypass, else the stored register value.
module regfile_rd_port
  import regfile_pkg::*;
(
  input  logic      rst,
  input  logic      re,
  input  reg_addr_t raddr,
  input  wr_req_t   wr,
  input  reg_word_t stored,
  output reg_word_t rdata
);

  // Priority select of the read value.
  always_comb begin
    rdata = ZERO_WORD;
    if (rst == RST_ENABLE) begin
      rdata = ZERO_WORD;
    end else if (re != READ_ENABLE) begin
      rdata = ZERO_WORD;
    end else if (raddr == NOP_REG_ADDR) begin
      rdata = ZERO_WORD;
    end else if (wr_hits(wr, raddr)) begin
      rdata = wr.data;
    end else begin
      rdata = stored;
    end
  end

endmodule

// File: rtl/regfile.sv
// Architectural integer register file: 32 x 32-bit, x0 reads zero, two
// same-cycle read ports with write bypass, a registered debug read port and
// a counter of committed non-x0 writes.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned REG_NUM   = 32,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 we_in,
  input  logic [4:0]           waddr_in,
  input  logic [31:0]          wdata_in,
  input  logic                 re1_in,
  input  logic [4:0]           raddr1_in,
  output logic [31:0]          rdata1_out,
  input  logic                 re2_in,
  input  logic [4:0]           raddr2_in,
  output logic [31:0]          rdata2_out,
  input  logic [4:0]           dbg_addr_in,
  output logic [31:0]          dbg_data_out,
  output logic [CNT_WIDTH-1:0] wr_count_out
);

  reg_word_t             regs [REG_NUM];
  wr_req_t               wr;
  reg_word_t             dbg_rd;
  logic [CNT_WIDTH-1:0]  wr_count;

  assign wr           = {we_in, waddr_in, wdata_in};
  assign wr_count_out = wr_count;

  // Register storage and retired-write counter; reset wins over a write.
  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ENABLE) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs[i] <= ZERO_WORD;
      end
      wr_count <= '0;
    end else if (we_in == WRITE_ENABLE && waddr_in != NOP_REG_ADDR) begin
      regs[waddr_in] <= wdata_in;
      wr_count       <= wr_count + CNT_WIDTH'(1);
    end
  end

  regfile_rd_port u_rd1 (
    .rst    (rst_in),
    .re     (re1_in),
    .raddr  (raddr1_in),
    .wr     (wr),
    .stored (regs[raddr1_in]),
    .rdata  (rdata1_out)
  );

  regfile_rd_port u_rd2 (
    .rst    (rst_in),
    .re     (re2_in),
    .raddr  (raddr2_in),
    .wr     (wr),
    .stored (regs[raddr2_in]),
    .rdata  (rdata2_out)
  );

  // Debug port always enabled; reset is applied at the output register.
  regfile_rd_port u_rd_dbg (
    .rst    (1'b0),
    .re     (READ_ENABLE),
    .raddr  (dbg_addr_in),
    .wr     (wr),
    .stored (regs[dbg_addr_in]),
    .rdata  (dbg_rd)
  );

  // Registered debug read, one cycle of latency.
  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ENABLE) begin
      dbg_data_out <= ZERO_WORD;
    end else begin
      dbg_data_out <= dbg_rd;
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        we_in = 1'b0;
  logic [4:0]  waddr_in = '0;
  logic [31:0] wdata_in = '0;
  logic        re1_in = 1'b0;
  logic [4:0]  raddr1_in = '0;
  logic        re2_in = 1'b0;
  logic [4:0]  raddr2_in = '0;
  logic [4:0]  dbg_addr_in = '0;

  logic [31:0] rdata1_out, rdata2_out, dbg_data_out, wr_count_out;
  logic [31:0] rdata1_w4, rdata2_w4, dbg_data_w4;
  logic [3:0]  wr_count_w4;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state
  logic [31:0] m_regs [32];
  int unsigned m_cnt;
  logic [31:0] m_dbg;

  always #5 clk_in = ~clk_in;

  regfile #(.REG_NUM(32), .CNT_WIDTH(32)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .we_in(we_in), .waddr_in(waddr_in),
    .wdata_in(wdata_in), .re1_in(re1_in), .raddr1_in(raddr1_in),
    .rdata1_out(rdata1_out), .re2_in(re2_in), .raddr2_in(raddr2_in),
    .rdata2_out(rdata2_out), .dbg_addr_in(dbg_addr_in),
    .dbg_data_out(dbg_data_out), .wr_count_out(wr_count_out)
  );

  regfile #(.REG_NUM(32), .CNT_WIDTH(4)) u_dut4 (
    .clk_in(clk_in), .rst_in(rst_in), .we_in(we_in), .waddr_in(waddr_in),
    .wdata_in(wdata_in), .re1_in(re1_in), .raddr1_in(raddr1_in),
    .rdata1_out(rdata1_w4), .re2_in(re2_in), .raddr2_in(raddr2_in),
    .rdata2_out(rdata2_w4), .dbg_addr_in(dbg_addr_in),
    .dbg_data_out(dbg_data_w4), .wr_count_out(wr_count_w4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // What a read request should return, from the architectural rules.
  function automatic logic [31:0] model_read(input logic rst, input logic re,
                                             input logic [4:0] addr);
    if (rst || !re || addr == 5'd0) return 32'h0;
    if (we_in && waddr_in == addr) return wdata_in;
    return m_regs[addr];
  endfunction

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic re1, input logic [4:0] a1,
                       input logic re2, input logic [4:0] a2, input logic [4:0] da);
    rst_in = rst; we_in = we; waddr_in = wa; wdata_in = wd;
    re1_in = re1; raddr1_in = a1; re2_in = re2; raddr2_in = a2; dbg_addr_in = da;
  endtask

  // One clock: check combinational reads, clock, update model, check state.
  task automatic step();
    logic [31:0] next_dbg;
    #1;
    check_eq("rd1", rdata1_out, model_read(rst_in, re1_in, raddr1_in));
    check_eq("rd2", rdata2_out, model_read(rst_in, re2_in, raddr2_in));
    check_eq("rd1_w4", rdata1_w4, model_read(rst_in, re1_in, raddr1_in));
    next_dbg = rst_in ? 32'h0 : model_read(1'b0, 1'b1, dbg_addr_in);
    @(posedge clk_in);
    if (rst_in) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_cnt = 0;
    end else if (we_in && waddr_in != 5'd0) begin
      m_regs[waddr_in] = wdata_in;
      m_cnt++;
    end
    m_dbg = next_dbg;
    #1;
    check_eq("count", wr_count_out, m_cnt);
    check_eq("count_w4", {28'h0, wr_count_w4}, m_cnt % 16);
    check_eq("dbg", dbg_data_out, m_dbg);
    @(negedge clk_in);
  endtask

  initial begin
    logic [4:0] wa, a1, a2;
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_cnt = 0;
    m_dbg = 32'h0;
    @(negedge clk_in);

    // Reset colliding with a write to x3
    drive(1, 1, 5'd3, 32'h000000AA, 1, 5'd3, 1, 5'd3, 5'd3);
    step();
    check_eq("rst_count", wr_count_out, 32'h0);
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(32 - i), 5'(i));
      step();
    end

    // Write then readback, then disabled read
    drive(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 5'd0, 5'd5);
    step();
    drive(0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd5, 5'd5);
    step();
    check_eq("wb_x5", rdata1_out, 32'hDEADBEEF);
    check_eq("wb_cnt", wr_count_out, 32'd1);
    check_eq("dbg_x5", dbg_data_out, 32'hDEADBEEF);
    drive(0, 0, 5'd0, 32'h0, 0, 5'd5, 0, 5'd5, 5'd5);
    #1 check_eq("re_off", rdata1_out, 32'h0);
    step();

    // x0 stays zero and the write is not counted
    drive(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0, 5'd0);
    step();
    check_eq("x0_cnt", wr_count_out, 32'd1);

    // Bypass: old x7=1, same-cycle write of 0x12345678 seen on both ports
    drive(0, 1, 5'd7, 32'h00000001, 0, 5'd0, 0, 5'd0, 5'd0);
    step();
    drive(0, 1, 5'd7, 32'h12345678, 1, 5'd7, 1, 5'd7, 5'd7);
    #1;
    check_eq("byp1", rdata1_out, 32'h12345678);
    check_eq("byp2", rdata2_out, 32'h12345678);
    step();
    drive(0, 0, 5'd0, 32'h0, 1, 5'd7, 1, 5'd7, 5'd7);
    step();
    check_eq("byp_held", rdata1_out, 32'h12345678);

    // Ten writes, then a mid-run reset clears everything
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 5'(i + 10), $urandom, 1, 5'(i + 9), 1, 5'(i + 10), 5'(i + 9));
      step();
    end
    drive(1, 0, 5'd0, 32'h0, 1, 5'd12, 1, 5'd13, 5'd12);
    step();
    check_eq("mid_rst_cnt", wr_count_out, 32'h0);
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(i), 5'(i));
      step();
    end

    // Sixteen counted writes wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 5'((i % 31) + 1), $urandom, 1, 5'(i + 1), 1, 5'(i), 5'(i));
      step();
    end
    check_eq("wrap_w4", {28'h0, wr_count_w4}, 32'h0);
    check_eq("wrap_w32", wr_count_out, 32'd16);

    // Randomized traffic, addresses biased low to provoke bypass hits
    for (int i = 0; i < 600; i++) begin
      wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), wa, $urandom,
            ($urandom_range(0, 4) != 0), a1, ($urandom_range(0, 4) != 0), a2,
            5'($urandom_range(0, 7)));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
